dfd_trace_funnel: RTL and testbench
===================================

# dfd_trace_funnel

Receive end of the cluster trace network: terminates the North and South branch outputs of the trace network and merges them into a single valid/ready trace stream for the downstream trace sink. Holds each branch in its own FIFO and generates the Ntrace/Dst backpressure, flush and enabled-source controls that the network distributes back to the cores. The branches have no ready signal, so this block must absorb every arriving beat; headroom comes from early backpressure.

## Interface
- NUM_CORES, 8, total cores; even; NUM_CORES_IN_PATH = NUM_CORES/2 per branch
- DATA_WIDTH_IN_BYTES, 16, beat width in bytes; DATA_WIDTH = 8*DATA_WIDTH_IN_BYTES
- FIFO_DEPTH, 16, entries per branch FIFO; power of 2, ≥ 8
- NTRACE_BP_THRESHOLD, 10, occupancy at or above which Ntrace_Bp asserts
- DST_BP_THRESHOLD, 6, occupancy at or above which Dst_Bp asserts; ≤ NTRACE_BP_THRESHOLD
- DRAIN_CYCLES, 8, consecutive quiet input cycles that end the flush phase

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- TN_TR_North_Vld  in  NUM_CORES_IN_PATH  one-hot valid; bit i = core 2i
- TN_TR_North_Src  in  1  0 = ntrace, 1 = dst
- TN_TR_North_Data  in  DATA_WIDTH  beat payload
- TN_TR_South_Vld  in  NUM_CORES_IN_PATH  one-hot valid; bit i = core 2i+1
- TN_TR_South_Src  in  1  as North
- TN_TR_South_Data  in  DATA_WIDTH  as North
- TN_TR_Ntrace_Bp  out  1  ntrace backpressure to network
- TN_TR_Dst_Bp  out  1  dst backpressure to network
- TN_TR_Ntrace_Flush  out  1  ntrace flush to network
- TN_TR_Dst_Flush  out  1  dst flush to network
- TN_TR_Enabled_Srcs  out  NUM_CORES  registered copy of cfg_enabled_srcs
- cfg_enabled_srcs  in  NUM_CORES  per-core trace enable
- flush_req  in  1  single-cycle flush request
- flush_done  out  1  single-cycle pulse when flush completes
- tr_out_vld  out  1  output beat valid
- tr_out_rdy  in  1  sink ready
- tr_out_src  out  1  source type of the beat
- tr_out_core_id  out  $clog2(NUM_CORES)  originating core
- tr_out_data  out  DATA_WIDTH  payload
- err_overflow  out  1  sticky: a beat was dropped on a full FIFO
- err_onehot  out  1  sticky: Vld was non-zero and not one-hot

## Operation
- Any non-zero Vld writes {Src, core_id, Data} into that branch's FIFO. core_id = 2*idx (North) or 2*idx+1 (South), where idx is the lowest set Vld bit.
- A non-one-hot Vld sets err_onehot and still writes using the lowest set bit.
- A write to a full FIFO drops the beat and sets err_overflow. FIFO contents are unchanged.
- Output arbitration is round-robin between non-empty FIFOs. A last-grant flag toggles only on an accepted beat (tr_out_vld & tr_out_rdy). With one FIFO non-empty, that FIFO is served. Per-branch order is preserved.
- Output holds stable while tr_out_vld & !tr_out_rdy.
- Occupancy counters are $clog2(FIFO_DEPTH+1) bits wide.
- Backpressure uses occ_max, the larger of the two branch occupancies:
  - Ntrace_Bp = registered (occ_max ≥ NTRACE_BP_THRESHOLD)
  - Dst_Bp = registered (occ_max ≥ DST_BP_THRESHOLD)
- Flush FSM:
  - IDLE: flush_req → FLUSH.
  - FLUSH: both Flush outputs = 1. A quiet counter increments each cycle with both Vld = 0 and resets to 0 on any valid. When it reaches DRAIN_CYCLES → DRAIN.
  - DRAIN: Flush outputs = 0. When both FIFOs are empty and tr_out_vld = 0 → DONE.
  - DONE: flush_done = 1 for one cycle → IDLE.
  - flush_req outside IDLE is ignored.
  - Beats keep being accepted and forwarded in every state.
- Sticky errors clear only on reset.

## Timing
- Reset values: all FIFOs empty, tr_out_vld = 0, all Bp/Flush = 0, flush_done = 0, errors = 0, Enabled_Srcs = 0, FSM = IDLE, last-grant = South (North wins first tie), quiet counter = 0.
- Input-to-output latency is 1 cycle: a beat written at edge N can be presented as tr_out_vld after edge N.
- Bp asserts the cycle after the threshold is crossed and deasserts the cycle after occ_max drops below it.
- Enabled_Srcs lags cfg_enabled_srcs by 1 cycle.
- A simultaneous write and read on a full FIFO is accepted: occupancy stays FIFO_DEPTH and no drop occurs. On an empty FIFO, bypass is not allowed; the beat is output the next cycle.
- Flush output timing:
  - Flush outputs rise 1 cycle after flush_req.
  - Minimum flush-to-done time is DRAIN_CYCLES + 2 cycles.
- Reset asserted mid-flush or mid-transfer returns to the reset state on the next edge. In-flight data is discarded.

## Configuration
- DFD_TRACE_FUNNEL_OVF_CNT_EN defined: adds output ovf_cnt [15:0], a saturating count of dropped beats summed across both branches (+2 when both drop in the same cycle), cleared by reset.
- Macro undefined: the port and counter are absent; only err_overflow reports drops.

## Test plan
- Reset, then North Vld = 4'b0100, Src = 1, Data = 0xA5.. → one cycle later tr_out_vld = 1, core_id = 4, src = 1, data = 0xA5.., accepted with rdy = 1.
- Both branches valid for 4 cycles with rdy = 1 → outputs alternate North/South (North first), and each branch's order is preserved.
- rdy = 0, North beats streamed → Dst_Bp rises after the 6th write and Ntrace_Bp after the 10th. The 17th write drops and sets err_overflow (ovf_cnt = 1 with the macro). Raising rdy drains the FIFO and Bp falls.
- Vld = 4'b0011 → err_onehot = 1, beat written with core_id 0 (North) or 1 (South).
- flush_req with traffic stopping 3 cycles later → Flush outputs high for 3 + DRAIN_CYCLES cycles, then DRAIN. flush_done pulses once the FIFOs are drained. A flush_req issued during FLUSH is ignored.
- reset asserted during DRAIN with FIFOs non-empty → next cycle all outputs are at reset values and the FSM is in IDLE.

Source files
------------

// File: rtl/dfd_trace_funnel.sv
// rtl/dfd_trace_funnel.sv - Trace network receive funnel merging North/South branch FIFOs into one stream.
// Define DFD_TRACE_FUNNEL_OVF_CNT_EN to add the saturating dropped-beat counter output ovf_cnt.
module dfd_trace_funnel #(
    parameter int NUM_CORES           = 8,
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int FIFO_DEPTH          = 16,
    parameter int NTRACE_BP_THRESHOLD = 10,
    parameter int DST_BP_THRESHOLD    = 6,
    parameter int DRAIN_CYCLES        = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CORES/2-1:0]               TN_TR_North_Vld,
    input  logic                                 TN_TR_North_Src,
    input  logic [8*DATA_WIDTH_IN_BYTES-1:0]     TN_TR_North_Data,
    input  logic [NUM_CORES/2-1:0]               TN_TR_South_Vld,
    input  logic                                 TN_TR_South_Src,
    input  logic [8*DATA_WIDTH_IN_BYTES-1:0]     TN_TR_South_Data,
    output logic                                 TN_TR_Ntrace_Bp,
    output logic                                 TN_TR_Dst_Bp,
    output logic                                 TN_TR_Ntrace_Flush,
    output logic                                 TN_TR_Dst_Flush,
    output logic [NUM_CORES-1:0]                 TN_TR_Enabled_Srcs,
    input  logic [NUM_CORES-1:0]                 cfg_enabled_srcs,
    input  logic                                 flush_req,
    output logic                                 flush_done,
    output logic                                 tr_out_vld,
    input  logic                                 tr_out_rdy,
    output logic                                 tr_out_src,
    output logic [$clog2(NUM_CORES)-1:0]         tr_out_core_id,
    output logic [8*DATA_WIDTH_IN_BYTES-1:0]     tr_out_data,
    output logic                                 err_overflow,
`ifdef DFD_TRACE_FUNNEL_OVF_CNT_EN
    output logic [15:0]                          ovf_cnt,
`endif
    output logic                                 err_onehot
);

    localparam int NCP  = NUM_CORES / 2;
    localparam int DW   = 8 * DATA_WIDTH_IN_BYTES;
    localparam int CIDW = $clog2(NUM_CORES);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int OCCW = $clog2(FIFO_DEPTH + 1);
    localparam int EW   = 1 + CIDW + DW;
    localparam int QW   = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DRAIN, S_DONE} state_t;

    logic [NCP-1:0]  w_vld   [2];
    logic [1:0]      w_src;
    logic [DW-1:0]   w_data  [2];
    logic [EW-1:0]   w_entry [2];
    logic [1:0]      w_wr, w_full, w_ne, w_rd, w_wr_ok, w_drop, w_multi;

    logic [EW-1:0]   r_mem  [2][FIFO_DEPTH];
    logic [AW-1:0]   r_wptr [2];
    logic [AW-1:0]   r_rptr [2];
    logic [OCCW-1:0] r_occ  [2];
    logic [OCCW-1:0] w_occ_max;

    logic            r_last, r_stall, r_sel;
    logic            w_arb, w_sel, w_acc;
    logic [EW-1:0]   w_head;

    state_t          r_state, w_state_nxt;
    logic [QW-1:0]   r_quiet, w_quiet_nxt;
    logic            w_quiet;

    logic            r_ntrace_bp, r_dst_bp, r_err_ovf, r_err_onehot;
    logic [NUM_CORES-1:0] r_enabled;

    assign w_vld[0]  = TN_TR_North_Vld;
    assign w_vld[1]  = TN_TR_South_Vld;
    assign w_src     = {TN_TR_South_Src, TN_TR_North_Src};
    assign w_data[0] = TN_TR_North_Data;
    assign w_data[1] = TN_TR_South_Data;

    // North carries even cores, South odd; the lowest set Vld bit picks the core.
    function automatic logic [CIDW-1:0] f_core_id(input logic [NCP-1:0] vld, input logic south);
        logic [CIDW-1:0] id;
        id = '0;
        for (int i = NCP - 1; i >= 0; i--) begin
            if (vld[i]) id = CIDW'(2 * i + int'(south));
        end
        return id;
    endfunction

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_wr[b]    = |w_vld[b];
            w_multi[b] = (w_vld[b] & (w_vld[b] - NCP'(1))) != '0;
            w_full[b]  = r_occ[b] == OCCW'(FIFO_DEPTH);
            w_ne[b]    = r_occ[b] != '0;
            w_entry[b] = {w_src[b], f_core_id(w_vld[b], b[0]), w_data[b]};
        end
    end

    // A stalled beat keeps its branch selected so the output cannot change under the sink.
    always_comb begin
        w_arb = 1'b0;
        if (&w_ne)
            w_arb = ~r_last;
        else if (w_ne[1])
            w_arb = 1'b1;
        w_sel  = r_stall ? r_sel : w_arb;
        w_head = r_mem[w_sel][r_rptr[w_sel]];
    end

    assign tr_out_vld = |w_ne;
    assign w_acc      = tr_out_vld & tr_out_rdy;
    assign {tr_out_src, tr_out_core_id, tr_out_data} = w_head;

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_rd[b]    = w_acc && (w_sel == b[0]);
            w_wr_ok[b] = w_wr[b] && (!w_full[b] || w_rd[b]);
            w_drop[b]  = w_wr[b] && w_full[b] && !w_rd[b];
        end
    end

    assign w_occ_max = (r_occ[0] > r_occ[1]) ? r_occ[0] : r_occ[1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (w_wr_ok[b]) r_mem[b][r_wptr[b]] <= w_entry[b];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                r_wptr[b] <= '0;
                r_rptr[b] <= '0;
                r_occ[b]  <= '0;
            end
            r_last       <= 1'b1;
            r_stall      <= 1'b0;
            r_sel        <= 1'b0;
            r_ntrace_bp  <= 1'b0;
            r_dst_bp     <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_onehot <= 1'b0;
            r_enabled    <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_wr_ok[b]) r_wptr[b] <= r_wptr[b] + AW'(1);
                if (w_rd[b])    r_rptr[b] <= r_rptr[b] + AW'(1);
                case ({w_wr_ok[b], w_rd[b]})
                    2'b10:   r_occ[b] <= r_occ[b] + OCCW'(1);
                    2'b01:   r_occ[b] <= r_occ[b] - OCCW'(1);
                    default: r_occ[b] <= r_occ[b];
                endcase
            end
            if (w_acc) r_last <= ~r_last;
            r_stall      <= tr_out_vld & ~tr_out_rdy;
            r_sel        <= w_sel;
            r_ntrace_bp  <= w_occ_max >= OCCW'(NTRACE_BP_THRESHOLD);
            r_dst_bp     <= w_occ_max >= OCCW'(DST_BP_THRESHOLD);
            r_err_ovf    <= r_err_ovf | (|w_drop);
            r_err_onehot <= r_err_onehot | (|w_multi);
            r_enabled    <= cfg_enabled_srcs;
        end
    end

    assign w_quiet = !(|w_wr);

    always_comb begin
        w_state_nxt = r_state;
        w_quiet_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (flush_req) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (w_quiet) begin
                    w_quiet_nxt = r_quiet + QW'(1);
                    if (r_quiet == QW'(DRAIN_CYCLES - 1)) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_ne == 2'b00 && !tr_out_vld) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_quiet <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_quiet <= w_quiet_nxt;
        end
    end

`ifdef DFD_TRACE_FUNNEL_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;
    logic [16:0] w_ovf_sum;

    assign w_ovf_sum = {1'b0, r_ovf_cnt} + 17'(w_drop[0]) + 17'(w_drop[1]);

    always_ff @(posedge clk) begin
        if (reset)
            r_ovf_cnt <= '0;
        else
            r_ovf_cnt <= w_ovf_sum[16] ? 16'hFFFF : w_ovf_sum[15:0];
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

    assign TN_TR_Ntrace_Bp    = r_ntrace_bp;
    assign TN_TR_Dst_Bp       = r_dst_bp;
    assign TN_TR_Ntrace_Flush = (r_state == S_FLUSH);
    assign TN_TR_Dst_Flush    = (r_state == S_FLUSH);
    assign flush_done         = (r_state == S_DONE);
    assign TN_TR_Enabled_Srcs = r_enabled;
    assign err_overflow       = r_err_ovf;
    assign err_onehot         = r_err_onehot;

endmodule

// File: tb/tb_dfd_trace_funnel.sv
// tb/tb_dfd_trace_funnel.sv - Scoreboard bench for dfd_trace_funnel with directed vectors.
module tb_dfd_trace_funnel;

    localparam int EW = 132;

    logic         clk, reset;
    logic [3:0]   n_vld, s_vld;
    logic         n_src, s_src;
    logic [127:0] n_data, s_data;
    logic         ntrace_bp, dst_bp, ntrace_flush, dst_flush;
    logic [7:0]   enabled, cfg;
    logic         flush_req, flush_done;
    logic         vld, rdy, src;
    logic [2:0]   core_id;
    logic [127:0] data;
    logic         err_ovf, err_oh;
`ifdef DFD_TRACE_FUNNEL_OVF_CNT_EN
    logic [15:0]  ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q [$];

    dfd_trace_funnel dut (
        .clk                (clk),
        .reset              (reset),
        .TN_TR_North_Vld    (n_vld),
        .TN_TR_North_Src    (n_src),
        .TN_TR_North_Data   (n_data),
        .TN_TR_South_Vld    (s_vld),
        .TN_TR_South_Src    (s_src),
        .TN_TR_South_Data   (s_data),
        .TN_TR_Ntrace_Bp    (ntrace_bp),
        .TN_TR_Dst_Bp       (dst_bp),
        .TN_TR_Ntrace_Flush (ntrace_flush),
        .TN_TR_Dst_Flush    (dst_flush),
        .TN_TR_Enabled_Srcs (enabled),
        .cfg_enabled_srcs   (cfg),
        .flush_req          (flush_req),
        .flush_done         (flush_done),
        .tr_out_vld         (vld),
        .tr_out_rdy         (rdy),
        .tr_out_src         (src),
        .tr_out_core_id     (core_id),
        .tr_out_data        (data),
        .err_overflow       (err_ovf),
`ifdef DFD_TRACE_FUNNEL_OVF_CNT_EN
        .ovf_cnt            (ovf_cnt),
`endif
        .err_onehot         (err_oh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] ent(input logic s, input logic [2:0] id, input logic [7:0] b);
        return {s, id, {16{b}}};
    endfunction

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_ent(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        n_vld = '0; s_vld = '0; n_src = 1'b0; s_src = 1'b0;
        n_data = '0; s_data = '0; flush_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_in();
        exp_q.delete();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            cyc();
        end
        chk_int(nm, exp_q.size(), 0);
        cyc();
        cyc();
    endtask

    task automatic check_reset_state(input string nm);
        chk_bit({nm, "_vld"}, vld, 1'b0);
        chk_bit({nm, "_ntrace_bp"}, ntrace_bp, 1'b0);
        chk_bit({nm, "_dst_bp"}, dst_bp, 1'b0);
        chk_bit({nm, "_ntrace_flush"}, ntrace_flush, 1'b0);
        chk_bit({nm, "_dst_flush"}, dst_flush, 1'b0);
        chk_bit({nm, "_flush_done"}, flush_done, 1'b0);
        chk_bit({nm, "_err_ovf"}, err_ovf, 1'b0);
        chk_bit({nm, "_err_oh"}, err_oh, 1'b0);
        chk_int({nm, "_enabled"}, int'(enabled), 0);
    endtask

    // Monitor: pops one expected beat per accepted output and checks stall stability.
    logic [EW-1:0] cur, held;
    logic          stalled;
    assign cur = {src, core_id, data};
    initial stalled = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk_bit("hold_vld", vld, 1'b1);
                chk_ent("hold_beat", cur, held);
            end
            if (vld && rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h want none", cur);
                end else begin
                    chk_ent("beat", cur, exp_q.pop_front());
                end
            end
            stalled = vld && !rdy;
            held    = cur;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int nf, nd, ndone, done_at;

    initial begin
        reset = 1'b1; rdy = 1'b0; cfg = '0;
        idle_in();
        cyc();
        cyc();
        check_reset_state("rst");
        reset = 1'b0;

        // Single North beat, core 4
        rdy = 1'b1; cfg = 8'h5A;
        n_vld = 4'b0100; n_src = 1'b1; n_data = {16{8'hA5}};
        exp_q.push_back(ent(1'b1, 3'd4, 8'hA5));
        chk_bit("t1_no_bypass", vld, 1'b0);
        chk_int("t1_en_lag", int'(enabled), 0);
        cyc();
        idle_in();
        chk_bit("t1_latency", vld, 1'b1);
        chk_int("t1_en", int'(enabled), 'h5A);
        wait_drain("t1_drain");

        // Both branches for 4 cycles: N0 S0 N1 S1 ...
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_vld = 4'b0001; n_src = i[0];  n_data = {16{8'(8'h10 + i)}};
            s_vld = 4'b1000; s_src = ~i[0]; s_data = {16{8'(8'h20 + i)}};
            exp_q.push_back(ent(i[0], 3'd0, 8'(8'h10 + i)));
            exp_q.push_back(ent(~i[0], 3'd7, 8'(8'h20 + i)));
            cyc();
        end
        idle_in();
        wait_drain("t2_drain");

        // Fill North with the sink stalled: backpressure thresholds and overflow
        rdy = 1'b0;
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            n_vld = 4'b0010; n_src = 1'b0; n_data = {16{8'(k)}};
            if (k <= 16) exp_q.push_back(ent(1'b0, 3'd2, 8'(k)));
            cyc();
            if (k == 6)  chk_bit("t3_dst_bp_after6", dst_bp, 1'b0);
            if (k == 7)  chk_bit("t3_dst_bp_after7", dst_bp, 1'b1);
            if (k == 10) chk_bit("t3_ntrace_bp_after10", ntrace_bp, 1'b0);
            if (k == 11) chk_bit("t3_ntrace_bp_after11", ntrace_bp, 1'b1);
            if (k == 16) chk_bit("t3_ovf_after16", err_ovf, 1'b0);
            if (k == 17) begin
                chk_bit("t3_ovf_after17", err_ovf, 1'b1);
`ifdef DFD_TRACE_FUNNEL_OVF_CNT_EN
                chk_int("t3_ovf_cnt", int'(ovf_cnt), 1);
`endif
            end
        end
        idle_in();
        rdy = 1'b1;
        wait_drain("t3_drain");
        chk_bit("t3_dst_bp_fall", dst_bp, 1'b0);
        chk_bit("t3_ntrace_bp_fall", ntrace_bp, 1'b0);
        chk_bit("t3_ovf_sticky", err_ovf, 1'b1);

        // Non-one-hot Vld on both branches
        do_reset();
        chk_bit("t4_oh_clear", err_oh, 1'b0);
        n_vld = 4'b0011; n_src = 1'b0; n_data = {16{8'hC3}};
        s_vld = 4'b0011; s_src = 1'b1; s_data = {16{8'h3C}};
        exp_q.push_back(ent(1'b0, 3'd0, 8'hC3));
        exp_q.push_back(ent(1'b1, 3'd1, 8'h3C));
        cyc();
        idle_in();
        chk_bit("t4_oh_set", err_oh, 1'b1);
        chk_bit("t4_no_ovf", err_ovf, 1'b0);
        wait_drain("t4_drain");

        // Flush with traffic for 3 cycles, a second request mid-flush
        do_reset();
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        nf = 0; nd = 0; ndone = 0; done_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (ntrace_flush) nf++;
            if (dst_flush) nd++;
            if (flush_done) begin
                ndone++;
                done_at = i;
            end
            idle_in();
            if (i < 3) begin
                n_vld = 4'b1000; n_src = 1'b1; n_data = {16{8'(8'h40 + i)}};
                exp_q.push_back(ent(1'b1, 3'd6, 8'(8'h40 + i)));
            end
            if (i == 5) flush_req = 1'b1;
            cyc();
        end
        idle_in();
        chk_int("t5_ntrace_flush_cycles", nf, 11);
        chk_int("t5_dst_flush_cycles", nd, 11);
        chk_int("t5_done_pulses", ndone, 1);
        chk_int("t5_done_cycle", done_at, 12);
        wait_drain("t5_drain");

        // Reset while in DRAIN with data held in both FIFOs
        rdy = 1'b0;
        do_reset();
        cfg = 8'hFF;
        n_vld = 4'b0101; n_src = 1'b0; n_data = {16{8'h77}};
        s_vld = 4'b0001; s_src = 1'b1; s_data = {16{8'h88}};
        cyc();
        idle_in();
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        chk_bit("t6_drain_flush_low", ntrace_flush, 1'b0);
        chk_bit("t6_drain_vld", vld, 1'b1);
        chk_bit("t6_drain_oh", err_oh, 1'b1);
        cyc();
        chk_bit("t6_drain_no_done", flush_done, 1'b0);
        reset = 1'b1;
        cyc();
        check_reset_state("t6_rst");
        reset = 1'b0;
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        chk_bit("t6_idle_accepts_req", ntrace_flush, 1'b1);
        chk_bit("t6_empty_after_rst", vld, 1'b0);

        rdy = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        chk_int("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
